// File: rtl/pc_next_unit_if.sv
// Fetch-side bundle between the ID stage/hazard unit and the PC register.
// Carries the redirect request from ID and returns the IF fetch address.
interface pc_next_unit_if;
    logic        stall;
    logic [1:0]  PCSel;
    logic        Branch;
    logic [31:0] PC_D;
    logic [15:0] Imm16_D;
    logic [25:0] Index26_D;
    logic [31:0] RS_D;
    logic [31:0] PC_F;
    logic [31:0] PC4_F;
    logic        Misalign_F;
    logic [31:0] BrTotal;
    logic [31:0] BrTaken;

    modport master (
        output stall, PCSel, Branch, PC_D, Imm16_D, Index26_D, RS_D,
        input  PC_F, PC4_F, Misalign_F, BrTotal, BrTaken
    );

    modport slave (
        input  stall, PCSel, Branch, PC_D, Imm16_D, Index26_D, RS_D,
        output PC_F, PC4_F, Misalign_F, BrTotal, BrTaken
    );
endinterface

// File: rtl/pc_next_unit.sv
// PC register and next-PC select; redirects resolve in ID with one delay slot.
// Define PC_BRANCH_STAT_EN to build the BrTotal/BrTaken branch counters.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    pc_next_unit_if.slave     pif
);
    logic [31:0] pc_q;
    logic        mis_q;
    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] nxt;
    logic        is_br;

    assign pc4    = pc_q + 32'd4;
    assign is_br  = (pif.PCSel == 2'b01);
    assign br_tgt = pif.PC_D + 32'd4
                  + {{14{pif.Imm16_D[15]}}, pif.Imm16_D, 2'b00};
    assign j_tgt  = {pif.PC_D[31:28], pif.Index26_D, 2'b00};

    always_comb begin
        nxt = pc4;
        unique case (1'b1)
            (is_br && pif.Branch):   nxt = br_tgt;
            (pif.PCSel == 2'b10):    nxt = j_tgt;
            (pif.PCSel == 2'b11):    nxt = pif.RS_D;
            default:                 nxt = pc4;
        endcase
    end

    // Misaligned targets are still loaded; the flag is for the exception logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
        end else if (!pif.stall) begin
            pc_q  <= nxt;
            mis_q <= |nxt[1:0];
        end
    end

    assign pif.PC_F       = pc_q;
    assign pif.PC4_F      = pc4;
    assign pif.Misalign_F = mis_q;

`ifdef PC_BRANCH_STAT_EN
    logic [31:0] tot_q;
    logic [31:0] tak_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tot_q <= 32'h0;
            tak_q <= 32'h0;
        end else if (!pif.stall && is_br) begin
            tot_q <= tot_q + 32'd1;
            if (pif.Branch)
                tak_q <= tak_q + 32'd1;
        end
    end

    assign pif.BrTotal = tot_q;
    assign pif.BrTaken = tak_q;
`else
    assign pif.BrTotal = 32'h0;
    assign pif.BrTaken = 32'h0;
`endif
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed scoreboard bench for pc_next_unit.
// Expected state comes from a reference model queued at drive time.
module tb_pc_next_unit;
    localparam logic [31:0] RST = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_next_unit_if pif ();

    pc_next_unit #(.RESET_PC(RST)) dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        mis;
        logic [31:0] tot;
        logic [31:0] tak;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_tot;
    logic [31:0] m_tak;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit st,
                        input logic [1:0] sel, input bit br,
                        input logic [31:0] pcd, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] rs);
        exp_t e;
        logic [31:0] tgt;
        reset         = rst;
        pif.stall     = st;
        pif.PCSel     = sel;
        pif.Branch    = br;
        pif.PC_D      = pcd;
        pif.Imm16_D   = imm;
        pif.Index26_D = idx;
        pif.RS_D      = rs;
        if (rst) begin
            m_pc = RST; m_mis = 1'b0; m_tot = 0; m_tak = 0;
        end else if (!st) begin
            case (sel)
                2'b01:   tgt = br ? pcd + 4 + 32'($signed(imm)) * 4
                              : m_pc + 4;
                2'b10:   tgt = {pcd[31:28], idx, 2'b00};
                2'b11:   tgt = rs;
                default: tgt = m_pc + 4;
            endcase
`ifdef PC_BRANCH_STAT_EN
            if (sel == 2'b01) begin
                m_tot = m_tot + 1;
                if (br) m_tak = m_tak + 1;
            end
`endif
            m_pc  = tgt;
            m_mis = (tgt[1:0] != 2'b00);
        end
        e.pc = m_pc; e.pc4 = m_pc + 4; e.mis = m_mis;
        e.tot = m_tot; e.tak = m_tak;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".pc"},  pif.PC_F, e.pc);
        chk({tag, ".pc4"}, pif.PC4_F, e.pc4);
        chk({tag, ".mis"}, {31'b0, pif.Misalign_F}, {31'b0, e.mis});
        chk({tag, ".tot"}, pif.BrTotal, e.tot);
        chk({tag, ".tak"}, pif.BrTaken, e.tak);
    endtask

    initial begin
        m_pc = 0; m_mis = 0; m_tot = 0; m_tak = 0;
        step("rst0", 1, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("rst0.const", pif.PC_F, 32'h3000);
        step("rst1", 1, 0, 2'b00, 0, 0, 0, 0, 0);
        step("seq0", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("seq0.const", pif.PC_F, 32'h3004);
        step("seq1", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("seq1.const", pif.PC_F, 32'h3008);

        step("brt", 0, 0, 2'b01, 1, 32'h3010, 16'hFFFC, 0, 0);
        chk("brt.const", pif.PC_F, 32'h3004);
        step("brn", 0, 0, 2'b01, 0, 32'h3010, 16'hFFFC, 0, 0);
        chk("brn.const", pif.PC_F, 32'h3008);
        step("brpos", 0, 0, 2'b01, 1, 32'h100, 16'h0010, 0, 0);
        chk("brpos.const", pif.PC_F, 32'h144);
        step("brneg", 0, 0, 2'b01, 1, 32'h0, 16'h8000, 0, 0);
        chk("brneg.const", pif.PC_F, 32'hFFFE_0004);

        step("jmp", 0, 0, 2'b10, 1, 32'h9000_0000, 0, 26'h0000C04, 0);
        chk("jmp.const", pif.PC_F, 32'h9000_3010);
        step("jr", 0, 0, 2'b11, 0, 0, 0, 0, 32'h3002);
        chk("jr.mis", {31'b0, pif.Misalign_F}, 32'd1);
        step("seqmis", 0, 0, 2'b00, 1, 0, 0, 0, 0);
        step("jrback", 0, 0, 2'b11, 0, 0, 0, 0, 32'h3000);

        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 2'b01, 1, 32'h3010, 16'hFFFC, 0, 0);
        chk("stall.const", pif.PC_F, 32'h3000);
        step("unstall", 0, 0, 2'b01, 1, 32'h3010, 16'hFFFC, 0, 0);
        step("after", 0, 0, 2'b00, 0, 0, 0, 0, 0);

        step("rstmid", 1, 1, 2'b01, 1, 32'h3010, 16'hFFFC, 0, 0);
        chk("rstmid.const", pif.PC_F, 32'h3000);
        step("rstjr", 1, 0, 2'b11, 0, 0, 0, 0, 32'h1234);

        step("prewrap", 0, 0, 2'b11, 0, 0, 0, 0, 32'hFFFF_FFFC);
        step("wrap", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("wrap.const", pif.PC_F, 32'h0);

`ifdef PC_BRANCH_STAT_EN
        force dut.tot_q = 32'hFFFF_FFFF;
        #1;
        release dut.tot_q;
        m_tot = 32'hFFFF_FFFF;
        step("cwrap", 0, 0, 2'b01, 0, 32'h0, 16'h0, 0, 0);
        chk("cwrap.const", pif.BrTotal, 32'h0);
`else
        step("nocnt", 0, 0, 2'b01, 1, 32'h10, 16'h1, 0, 0);
        chk("nocnt.tot", pif.BrTotal, 32'h0);
        chk("nocnt.tak", pif.BrTaken, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter register and next-PC selector for the five-stage MIPS pipeline, sitting directly downstream of the ID-stage branch comparator. It consumes the comparator's `Branch` decision with the decoded jump mode and the ID-stage instruction fields, and produces the IF-stage fetch address. Branches and jumps resolve in ID with one architectural delay slot, so a redirect replaces the sequential fetch on the cycle after resolution. An optional pair of branch statistics counters can be compiled in.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high; dominates all other inputs.
- `stall`  input  1  from hazard unit; 1 = hold PC and counters.
- `PCSel`  input  2  ID-stage next-PC mode: 00 sequential, 01 conditional branch, 10 j/jal, 11 jr/jalr.
- `Branch`  input  1  comparator result for the ID instruction; meaningful only when `PCSel`=01.
- `PC_D`  input  32  PC of the instruction currently in ID.
- `Imm16_D`  input  16  ID instruction bits [15:0].
- `Index26_D`  input  26  ID instruction bits [25:0].
- `RS_D`  input  32  forwarded GPR[rs] value (jr target).
- `PC_F`  output  32  registered fetch address.
- `PC4_F`  output  32  `PC_F`+4, combinational.
- `Misalign_F`  output  1  registered; 1 when `PC_F[1:0]`≠00.
- `BrTotal`  output  32  conditional branches retired from ID (see Configuration).
- `BrTaken`  output  32  of those, how many were taken.

## Operation
- Targets, all combinational from ID inputs:
  - branch target = `PC_D` + 4 + (sign-extend(`Imm16_D`) << 2), 32-bit modulo arithmetic.
  - jump target = {`PC_D`[31:28], `Index26_D`, 2'b00}; the region comes from `PC_D`, not `PC_F`.
  - jr target = `RS_D` unmodified; low bits are not masked.
- Next PC:
  - `PCSel`=01 and `Branch`=1 → branch target.
  - `PCSel`=01 and `Branch`=0 → `PC_F`+4.
  - `PCSel`=10 → jump target.
  - `PCSel`=11 → jr target.
  - `PCSel`=00 → `PC_F`+4.
- Update priority per edge: `reset` → `PC_F`=`RESET_PC`, `Misalign_F`=0, counters=0; else `stall` → all state holds; else `PC_F`←next PC and `Misalign_F`←(next PC[1:0]≠0).
- A misaligned PC is still loaded; `Misalign_F` is a flag only, and the exception logic decides what happens next.
- The `Branch` input is ignored whenever `PCSel`≠01.
- Counters: on a non-stalled, non-reset edge with `PCSel`=01, `BrTotal`+1; if `Branch`=1 as well, `BrTaken`+1. Both wrap from 32'hFFFF_FFFF to 0 silently.

## Timing
- Reset values: `PC_F`=`RESET_PC`, `PC4_F`=`RESET_PC`+4, `Misalign_F`=0, `BrTotal`=0, `BrTaken`=0.
- Redirect latency is one cycle. A branch or jump in ID at cycle N gives `PC_F` = target at N+1. The instruction fetched at N is the delay slot and is never squashed here.
- Stall: while `stall`=1, `PC_F` keeps its value indefinitely. A redirect presented during a stall is not remembered. The hazard unit holds the ID instruction, so the redirect is taken on the first unstalled edge.
- Reset asserted mid-redirect or mid-stall: `RESET_PC` is loaded on that edge, and the pending redirect and counter increment are dropped.
- `PC4_F` and `Misalign_F` always track the current `PC_F`, with no extra latency.
- Wrap: `PC_F`=32'hFFFF_FFFC with `PCSel`=00 gives next `PC_F`=0.

## Configuration
- `PC_BRANCH_STAT_EN` defined: `BrTotal`/`BrTaken` registers and incrementers are built as described.
- Not defined: no counter registers exist, and both ports are tied to 32'h0. All other behaviour is identical.

## Test plan
- Reset held 2 cycles, then released with `PCSel`=00 → `PC_F` goes 0x3000, 0x3000, then 0x3004, 0x3008; `Misalign_F`=0.
- `PC_D`=0x3010, `Imm16_D`=16'hFFFC, `PCSel`=01, `Branch`=1 → next `PC_F`=0x3004 and `BrTaken`+1. Same stimulus with `Branch`=0 → `PC_F`+4, and only `BrTotal` increments.
- `PC_D`=0x9000_0000, `Index26_D`=26'h0000C04, `PCSel`=10 → next `PC_F`=0x9000_3010.
- `PCSel`=11, `RS_D`=0x0000_3002 → `PC_F`=0x3002 with `Misalign_F`=1 on the same cycle.
- `stall`=1 for 3 cycles with `PCSel`=01, `Branch`=1 → `PC_F` and counters unchanged. After `stall` drops, one redirect occurs and the counters increment exactly once.
- Preload `PC_F`=0xFFFF_FFFC, `PCSel`=00 → `PC_F`=0. With the macro defined, force `BrTotal` to 0xFFFF_FFFF and retire a branch → `BrTotal`=0. With the macro undefined, both counters read 0 throughout.
